// File: rtl/cpu_mult_pipe.sv
// cpu_mult_pipe: 3-stage pipelined DATA_W x DATA_W multiplier.
// Stage 1 forms four half-width partial products, stage 2 sums them into the
// full unsigned product, stage 3 applies signed correction to the high word and
// selects the result word. Global stall: every stage holds while the tail is
// full and the consumer is not ready.
module cpu_mult_pipe #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_src1,
   input  logic [DATA_W-1:0] in_src2,
   input  logic [1:0]        in_op,
   input  logic [4:0]        in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [4:0]        out_tag,
   output logic              busy
);

   localparam int unsigned HALF_W = DATA_W / 2;
   localparam int unsigned PW     = 2 * HALF_W;
   localparam int unsigned SW     = 2 * DATA_W;

   logic              w_adv;
   logic [HALF_W-1:0] w_a_lo, w_a_hi, w_b_lo, w_b_hi;
   logic              w_nega, w_negb;
   logic [DATA_W-1:0] w_hi_corr;

   // stage 1
   logic              r_s1_valid;
   logic [PW-1:0]     r_p_ll, r_p_lh, r_p_hl, r_p_hh;
   logic [1:0]        r_s1_op;
   logic [4:0]        r_s1_tag;
   logic              r_s1_nega, r_s1_negb;
   logic [DATA_W-1:0] r_s1_a, r_s1_b;

   // stage 2
   logic              r_s2_valid;
   logic [SW-1:0]     r_s2_sum;
   logic [1:0]        r_s2_op;
   logic [4:0]        r_s2_tag;
   logic              r_s2_nega, r_s2_negb;
   logic [DATA_W-1:0] r_s2_a, r_s2_b;

   // stage 3
   logic              r_s3_valid;
   logic [DATA_W-1:0] r_s3_result;
   logic [4:0]        r_s3_tag;

   assign w_adv    = ~r_s3_valid | out_ready;
   assign in_ready = w_adv;

   assign w_a_lo = in_src1[HALF_W-1:0];
   assign w_a_hi = in_src1[DATA_W-1:HALF_W];
   assign w_b_lo = in_src2[HALF_W-1:0];
   assign w_b_hi = in_src2[DATA_W-1:HALF_W];

   // A is signed for MULXSU/MULXSS, B only for MULXSS
   assign w_nega = in_src1[DATA_W-1] & in_op[1];
   assign w_negb = in_src2[DATA_W-1] & (in_op == 2'b11);

   // High word of the signed product: unsigned high word minus the operand
   // that a negative counterpart's 2^DATA_W weight would have contributed.
   assign w_hi_corr = r_s2_sum[SW-1:DATA_W]
                    - (r_s2_nega ? r_s2_b : '0)
                    - (r_s2_negb ? r_s2_a : '0);

   // Stage 1: capture partial products, operands and sign flags
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_p_ll     <= '0;
         r_p_lh     <= '0;
         r_p_hl     <= '0;
         r_p_hh     <= '0;
         r_s1_op    <= '0;
         r_s1_tag   <= '0;
         r_s1_nega  <= 1'b0;
         r_s1_negb  <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
      end else if (w_adv) begin
         r_s1_valid <= in_valid;
         r_p_ll     <= PW'(w_a_lo) * PW'(w_b_lo);
         r_p_lh     <= PW'(w_a_lo) * PW'(w_b_hi);
         r_p_hl     <= PW'(w_a_hi) * PW'(w_b_lo);
         r_p_hh     <= PW'(w_a_hi) * PW'(w_b_hi);
         r_s1_op    <= in_op;
         r_s1_tag   <= in_tag;
         r_s1_nega  <= w_nega;
         r_s1_negb  <= w_negb;
         r_s1_a     <= in_src1;
         r_s1_b     <= in_src2;
      end
   end

   // Stage 2: sum partial products into the full unsigned product
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s2_valid <= 1'b0;
         r_s2_sum   <= '0;
         r_s2_op    <= '0;
         r_s2_tag   <= '0;
         r_s2_nega  <= 1'b0;
         r_s2_negb  <= 1'b0;
         r_s2_a     <= '0;
         r_s2_b     <= '0;
      end else if (w_adv) begin
         r_s2_valid <= r_s1_valid;
         r_s2_sum   <= SW'(r_p_ll)
                     + (SW'(r_p_lh) << HALF_W)
                     + (SW'(r_p_hl) << HALF_W)
                     + (SW'(r_p_hh) << DATA_W);
         r_s2_op    <= r_s1_op;
         r_s2_tag   <= r_s1_tag;
         r_s2_nega  <= r_s1_nega;
         r_s2_negb  <= r_s1_negb;
         r_s2_a     <= r_s1_a;
         r_s2_b     <= r_s1_b;
      end
   end

   // Stage 3: sign-correct the high word and select the result word
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s3_valid  <= 1'b0;
         r_s3_result <= '0;
         r_s3_tag    <= '0;
      end else if (w_adv) begin
         r_s3_valid  <= r_s2_valid;
         r_s3_result <= (r_s2_op == 2'b00) ? r_s2_sum[DATA_W-1:0] : w_hi_corr;
         r_s3_tag    <= r_s2_tag;
      end
   end

   assign out_valid  = r_s3_valid;
   assign out_result = r_s3_result;
   assign out_tag    = r_s3_tag;
   assign busy       = r_s1_valid | r_s2_valid | r_s3_valid;

endmodule

// File: tb/tb_cpu_mult_pipe.sv
// Bench for cpu_mult_pipe: three instances (16/32/64-bit) share one stimulus
// stream; a scoreboard per instance checks every delivered result against a
// wide-integer reference product. Directed sequences target the 32-bit DUT.
module tb_cpu_mult_pipe;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        in_valid;
   logic        out_ready;
   logic [63:0] src1, src2;
   logic [1:0]  op;
   logic [4:0]  tag;

   logic        rdy  [3];
   logic        ov   [3];
   logic        bsy  [3];
   logic [4:0]  otag [3];
   logic [63:0] res  [3];
   logic [15:0] r16;
   logic [31:0] r32;
   logic [63:0] r64;

   assign res[0] = {48'b0, r16};
   assign res[1] = {32'b0, r32};
   assign res[2] = r64;

   cpu_mult_pipe #(.DATA_W(16)) u16 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
      .in_src1(src1[15:0]), .in_src2(src2[15:0]), .in_op(op), .in_tag(tag),
      .out_valid(ov[0]), .out_ready(out_ready), .out_result(r16),
      .out_tag(otag[0]), .busy(bsy[0]));

   cpu_mult_pipe #(.DATA_W(32)) u32 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
      .in_src1(src1[31:0]), .in_src2(src2[31:0]), .in_op(op), .in_tag(tag),
      .out_valid(ov[1]), .out_ready(out_ready), .out_result(r32),
      .out_tag(otag[1]), .busy(bsy[1]));

   cpu_mult_pipe #(.DATA_W(64)) u64 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[2]),
      .in_src1(src1), .in_src2(src2), .in_op(op), .in_tag(tag),
      .out_valid(ov[2]), .out_ready(out_ready), .out_result(r64),
      .out_tag(otag[2]), .busy(bsy[2]));

   int unsigned n_pass = 0;
   int unsigned n_chk  = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   // Reference: exact product of the (optionally signed) operands, word-selected.
   function automatic logic [63:0] refm(input int unsigned w, input logic [63:0] a,
                                        input logic [63:0] b, input logic [1:0] o);
      logic signed [129:0] ea, eb, p;
      logic [63:0] m;
      m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      ea = 130'(a & m);
      eb = 130'(b & m);
      if (o[1] && a[w-1])       ea = ea - (130'sd1 <<< w);
      if (o == 2'b11 && b[w-1]) eb = eb - (130'sd1 <<< w);
      p = ea * eb;
      if (o == 2'b00) return 64'(p) & m;
      return 64'(p >>> w) & m;
   endfunction

   function automatic logic [63:0] pick();
      case ($urandom_range(7))
         0:       return '1;
         1:       return '0;
         2:       return 64'h8000_0000_8000_8000;
         3:       return 64'h0000_0000_8000_0000;
         4:       return 64'h0000_0000_0000_8000;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   typedef struct packed {
      logic [63:0] r;
      logic [4:0]  t;
   } exp_t;

   exp_t q0[$], q1[$], q2[$];

   // Scoreboard: push expected on accept, pop and compare on delivery
   always @(negedge clk) begin
      exp_t e;
      int   sz;
      int unsigned w;
      for (int i = 0; i < 3; i++) begin
         w = 16 << i;
         if (reset) begin
            case (i)
               0:       q0.delete();
               1:       q1.delete();
               default: q2.delete();
            endcase
         end else begin
            if (ov[i] && out_ready) begin
               case (i)
                  0:       sz = q0.size();
                  1:       sz = q1.size();
                  default: sz = q2.size();
               endcase
               check($sformatf("sb_pending_w%0d", w), 64'(sz != 0), 64'd1);
               if (sz != 0) begin
                  case (i)
                     0:       e = q0.pop_front();
                     1:       e = q1.pop_front();
                     default: e = q2.pop_front();
                  endcase
                  check($sformatf("sb_result_w%0d", w), res[i], e.r);
                  check($sformatf("sb_tag_w%0d", w), 64'(otag[i]), 64'(e.t));
               end
            end
            if (in_valid && rdy[i]) begin
               e.r = refm(w, src1, src2, op);
               e.t = tag;
               case (i)
                  0:       q0.push_back(e);
                  1:       q1.push_back(e);
                  default: q2.push_back(e);
               endcase
            end
         end
      end
   end

   // Issue up to 4 ops back-to-back into an empty pipe; expect results on
   // consecutive cycles, each on the 3rd edge after its accept.
   task automatic burst(input int n, input logic [63:0] a[4], input logic [63:0] b[4],
                        input logic [1:0] o[4], input logic [31:0] ex[4], input logic [4:0] tag0);
      int k = 0;
      for (int e = 0; e < n + 6; e++) begin
         if (e < n) begin
            in_valid = 1'b1; src1 = a[e]; src2 = b[e]; op = o[e]; tag = tag0 + 5'(e);
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk); #1;
         if (ov[1]) begin
            check("burst_latency", 64'(e), 64'(k + 2));
            if (k < n) begin
               check("burst_result", res[1], {32'b0, ex[k]});
               check("burst_tag", 64'(otag[1]), 64'(tag0 + 5'(k)));
            end
            k++;
         end
      end
      check("burst_count", 64'(k), 64'(n));
   endtask

   function automatic logic [63:0] bp_a(input int t);
      return 64'(32'h1357_9BDF + 32'(t) * 32'h1111_1111);
   endfunction
   function automatic logic [63:0] bp_b(input int t);
      return 64'(32'hFEDC_0000 | 32'(t));
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] a[4], b[4];
      logic [1:0]  o[4];
      logic [31:0] ex[4];
      int issued, next_tag, hold, cyc;
      bit started, acc;

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      src1 = '0; src2 = '0; op = '0; tag = '0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(ov[1]), 64'd0);
      check("rst_out_result", res[1], 64'd0);
      check("rst_out_tag", 64'(otag[1]), 64'd0);
      check("rst_busy", 64'(bsy[1]), 64'd0);
      check("rst_in_ready", 64'(rdy[1]), 64'd1);
      // handshake during reset must not be captured
      in_valid = 1'b1; src1 = 64'd9; src2 = 64'd9; tag = 5'd3;
      @(posedge clk); #1;
      reset = 1'b0; in_valid = 1'b0;
      check("rst_no_capture_busy", 64'(bsy[1]), 64'd0);
      @(posedge clk); #1;

      // single op
      a  = '{64'd3, 64'd0, 64'd0, 64'd0};
      b  = '{64'd5, 64'd0, 64'd0, 64'd0};
      o  = '{2'b00, 2'b00, 2'b00, 2'b00};
      ex = '{32'h0000_000F, 32'd0, 32'd0, 32'd0};
      burst(1, a, b, o, ex, 5'd7);

      // high-word modes back-to-back
      a  = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd0};
      b  = '{64'd2, 64'd2, 64'd2, 64'd0};
      o  = '{2'b01, 2'b11, 2'b10, 2'b00};
      ex = '{32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
      burst(3, a, b, o, ex, 5'd10);

      // signed extremes
      a  = '{64'h8000_0000, 64'h8000_0000, 64'h8000_0000, 64'h8000_0000};
      b  = '{64'h8000_0000, 64'h8000_0000, 64'h8000_0000, 64'hFFFF_FFFF};
      o  = '{2'b11, 2'b01, 2'b00, 2'b10};
      ex = '{32'h4000_0000, 32'h4000_0000, 32'h0000_0000, 32'h8000_0000};
      burst(4, a, b, o, ex, 5'd20);

      // backpressure: 6 ops, hold out_ready low 4 cycles once tag 1 is at the output
      issued = 0; next_tag = 1; hold = 0; started = 0;
      for (int c = 0; c < 60; c++) begin
         if (!started && ov[1] && otag[1] == 5'd1) begin
            started = 1; hold = 4;
         end
         out_ready = (hold == 0);
         in_valid  = (issued < 6);
         src1 = bp_a(issued + 1); src2 = bp_b(issued + 1);
         op = 2'(issued + 1); tag = 5'(issued + 1);
         @(negedge clk);
         if (hold > 0) begin
            check("bp_in_ready_low", 64'(rdy[1]), 64'd0);
            check("bp_valid_held", 64'(ov[1]), 64'd1);
            check("bp_result_held", res[1], refm(32, bp_a(1), bp_b(1), 2'd1));
            check("bp_tag_held", 64'(otag[1]), 64'd1);
            hold--;
         end
         if (in_valid && rdy[1]) issued++;
         if (ov[1] && out_ready) begin
            check("bp_order", 64'(otag[1]), 64'(next_tag));
            next_tag++;
         end
         @(posedge clk); #1;
         if (next_tag == 7) break;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      check("bp_hold_seen", 64'(started), 64'd1);
      check("bp_all_delivered", 64'(next_tag), 64'd7);

      // reset with every stage occupied
      for (int e = 0; e < 3; e++) begin
         in_valid = 1'b1; src1 = 64'(e + 11); src2 = 64'(e + 13); op = 2'(e); tag = 5'(e + 1);
         @(posedge clk); #1;
      end
      check("mid_busy_before", 64'(bsy[1]), 64'd1);
      check("mid_valid_before", 64'(ov[1]), 64'd1);
      reset = 1'b1; src1 = 64'd99; tag = 5'd30;
      @(posedge clk); #1;
      reset = 1'b0; in_valid = 1'b0;
      check("mid_out_valid", 64'(ov[1]), 64'd0);
      check("mid_busy", 64'(bsy[1]), 64'd0);
      for (int e = 0; e < 3; e++) begin
         @(posedge clk); #1;
         check("mid_no_pulse", 64'(ov[1]), 64'd0);
      end
      a  = '{64'h0001_0000, 64'd0, 64'd0, 64'd0};
      b  = '{64'hFFFF_FFFF, 64'd0, 64'd0, 64'd0};
      o  = '{2'b11, 2'b00, 2'b00, 2'b00};
      ex = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
      burst(1, a, b, o, ex, 5'd5);

      // random sweep on all widths: 1000 ops per op code, random backpressure
      issued = 0; cyc = 0; in_valid = 1'b0;
      while (issued < 4000 && cyc < 40000) begin
         if (!in_valid && $urandom_range(3) != 0) begin
            in_valid = 1'b1; op = 2'(issued); src1 = pick(); src2 = pick();
            tag = 5'($urandom);
         end
         out_ready = ($urandom_range(9) < 7);
         @(negedge clk);
         acc = in_valid && rdy[1];
         if (acc) issued++;
         @(posedge clk); #1;
         if (acc) in_valid = 1'b0;
         cyc++;
      end
      check("rand_issued", 64'(issued), 64'd4000);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("drain_q16", 64'(q0.size()), 64'd0);
      check("drain_q32", 64'(q1.size()), 64'd0);
      check("drain_q64", 64'(q2.size()), 64'd0);
      check("drain_busy", 64'(bsy[1]), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/cpu_mult_pipe.md
Name: cpu_mult_pipe

Overview:
- Parametrised successor of the CPU multiply cell. It computes the full 2*DATA_W product from four registered half-width partial products (lo*lo, lo*hi, hi*lo, hi*hi), instead of leaving partial-product summation to the ALU.
- Supports Nios II-style low-word and high-word multiply modes with signed/unsigned operand selection.
- Fixed 3-stage pipeline with valid/ready handshake and backpressure.
- Sits between the E-stage operand bus and the M/W-stage result mux.

Parameters:
- DATA_W, 32, operand and result width. Must be even, 8..64.
- HALF_W, DATA_W/2, partial-product operand width. Derived; not to be overridden.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  one clock; reset is synchronous and active-high
- in_valid  in  1  operands/op valid this cycle
- in_ready  out  1  block accepts operands this cycle
- in_src1  in  DATA_W  operand A
- in_src2  in  DATA_W  operand B
- in_op  in  2  00=MUL (low word), 01=MULXUU, 10=MULXSU (A signed, B unsigned), 11=MULXSS
- in_tag  in  5  destination-register tag, carried with the op
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  DATA_W  selected product word
- out_tag  out  5  tag of the op in out_result
- busy  out  1  any stage holds a valid op

Behaviour:
- Reset: all stage valid bits are 0 and all data registers are 0. Therefore out_valid=0, out_result=0, out_tag=0, busy=0.
- in_ready is not gated by reset. During reset, in_ready=1, but no op is captured.
- Pipeline advance: adv = ~s3_valid | out_ready. in_ready = adv.
  - When adv=1, every stage shifts forward; s1_valid <= in_valid.
  - When adv=0, every stage holds. This is a global stall with no bubble collapsing.
- Stage 1 registers:
  - the four unsigned HALF_W x HALF_W partial products (each 2*HALF_W wide)
  - op, tag
  - sign-correction flags: negA = A[MSB] & (op==10 | op==11); negB = B[MSB] & (op==11)
  - registered copies of A and B
- Stage 2 registers the 2*DATA_W unsigned sum: p_ll + (p_lh<<HALF_W) + (p_hl<<HALF_W) + (p_hh<<DATA_W), truncated to 2*DATA_W.
- Stage 3 registers:
  - signed correction on the high word: hi - (negA ? B : 0) - (negB ? A : 0), modulo 2^DATA_W
  - result select: op==00 gives the low word, otherwise the corrected high word
  - out_result = s3 data register; out_tag = s3 tag; out_valid = s3_valid
- Latency: exactly 3 cycles from accept (in_valid & in_ready) to out_valid, with no stalls. Each cycle with adv=0 adds 1 cycle.
- Throughput: 1 op/cycle while out_ready=1.
- Holding rule: out_result/out_tag hold stable while out_valid=1 & out_ready=0.
- Ordering: ops never drop or reorder. Result k corresponds to accept k.
- Stall with an empty tail: if s3_valid=0, adv=1 regardless of out_ready. Bubbles never block.
- Simultaneous accept and drain: when out_ready=1 and in_valid=1 with the pipe full, the s3 result leaves and the new op enters s1 in the same cycle.
- Reset mid-operation: all in-flight ops are discarded, with no output pulse. A handshake asserted in the reset cycle is ignored.
- busy = s1_valid | s2_valid | s3_valid.
- When a stage's valid=0, its data registers may hold stale values, but out_result must only be sampled when out_valid=1.
- Implementation constraints:
  - Partial products are inferred `*` on HALF_W operands so they map to DSP blocks.
  - No vendor primitives.

Test Plan:
- Reset then single op: A=0x0000_0003, B=0x0000_0005, op=00, tag=7 -> out_valid on the 3rd edge after accept, out_result=0x0000_000F, out_tag=7; then out_valid=0.
- High-word modes, each issued back-to-back on consecutive cycles, with A=0xFFFF_FFFF and B=0x0000_0002:
  - op=01 -> 0x0000_0001
  - op=11 -> 0xFFFF_FFFF
  - op=10 -> 0xFFFF_FFFF
  - Results arrive on three consecutive cycles, in order.
- Signed extreme: A=0x8000_0000, B=0x8000_0000:
  - op=11 -> 0x4000_0000
  - op=01 -> 0x4000_0000
  - op=00 -> 0x0000_0000
  - op=10 with B=0xFFFF_FFFF -> 0x8000_0000
- Backpressure: stream 6 ops with tags 1..6 and hold out_ready=0 for 4 cycles once tag 1 reaches stage 3.
  - in_ready=0 during the hold.
  - out_result/out_tag stay stable during the hold.
  - After release, tags 1..6 appear in order with none lost.
- Reset mid-flight: issue 3 ops, then assert reset for 1 cycle while all stages are valid.
  - Next cycle: out_valid=0, busy=0.
  - A new op afterwards returns its correct result after 3 cycles.
- Parameter sweep: DATA_W=16 and DATA_W=64, 1000 random ops per op code each, with random out_ready.
  - Every result matches a reference model: full signed/unsigned product, word-selected by op.
